// File: rtl/subbytes_seq.sv
// Byte-serial SubBytes sequencer: one shared S-box processes NBYTES bytes per transaction.
// Define SUBBYTES_SEQ_SBOX_REG_EN to register the S-box output before capture (+1 cycle latency).
module subbytes_seq #(
    parameter int unsigned NBYTES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [8*NBYTES-1:0]   in_data,
    input  logic                  in_encrypt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [8*NBYTES-1:0]   out_data,
    output logic                  busy,
    output logic [7:0]            sbox_byte_in,
    output logic                  sbox_encrypt,
    input  logic [7:0]            sbox_byte_out
);

    localparam int unsigned IdxW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NBYTES - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    logic [8*NBYTES-1:0]  src_q, src_d;
    logic [8*NBYTES-1:0]  res_q, res_d;
    logic                 mode_q, mode_d;
    logic [IdxW-1:0]      idx_q, idx_d;

    logic                 cap_en;
    logic [7:0]           cap_byte;
    logic                 drv_en;
    logic [IdxW-1:0]      drv_idx;

`ifdef SUBBYTES_SEQ_SBOX_REG_EN
    logic [7:0] sbox_out_q;
    logic       prime_q, prime_d;

    // prime_q marks the first RUN cycle, when the S-box register holds nothing useful yet.
    always_comb begin
        prime_d = (state_q == StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sbox_out_q <= 8'h00;
            prime_q    <= 1'b1;
        end else begin
            sbox_out_q <= sbox_byte_out;
            prime_q    <= prime_d;
        end
    end

    // idx_q is the capture index; the drive index runs one byte ahead of it.
    always_comb begin
        cap_en   = (state_q == StRun) && !prime_q;
        cap_byte = sbox_out_q;
        drv_en   = (state_q == StRun) && (prime_q || (idx_q != LastIdx));
        drv_idx  = prime_q ? '0 : idx_q + 1'b1;
    end
`else
    always_comb begin
        cap_en   = (state_q == StRun);
        cap_byte = sbox_byte_out;
        drv_en   = (state_q == StRun);
        drv_idx  = idx_q;
    end
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        res_d   = res_q;
        mode_d  = mode_q;
        idx_d   = idx_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    src_d   = in_data;
                    mode_d  = in_encrypt;
                    idx_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cap_en) begin
                    res_d[{idx_q, 3'b000} +: 8] = cap_byte;
                    if (idx_q == LastIdx) begin
                        state_d = StDone;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            src_q   <= '0;
            res_q   <= '0;
            mode_q  <= 1'b1;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            res_q   <= res_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        in_ready     = (state_q == StIdle);
        out_valid    = (state_q == StDone);
        busy         = (state_q != StIdle);
        out_data     = res_q;
        sbox_encrypt = mode_q;
        sbox_byte_in = drv_en ? src_q[{drv_idx, 3'b000} +: 8] : 8'h00;
    end

endmodule

// File: tb/tb_subbytes_seq.sv
// Scoreboard bench for subbytes_seq: a 16-byte and a 4-byte instance, each wired to a
// behavioural S-box built from GF(2^8) inversion plus the AES affine map.
module tb_subbytes_seq;

`ifdef SUBBYTES_SEQ_SBOX_REG_EN
    localparam int Extra = 1;
`else
    localparam int Extra = 0;
`endif
    localparam int NA = 16;
    localparam int NB = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic         a_in_valid, a_in_ready, a_in_encrypt, a_out_valid, a_out_ready, a_busy;
    logic [127:0] a_in_data, a_out_data;
    logic [7:0]   a_sbox_in, a_sbox_out;
    logic         a_sbox_enc;

    logic         b_in_valid, b_in_ready, b_in_encrypt, b_out_valid, b_out_ready, b_busy;
    logic [31:0]  b_in_data, b_out_data;
    logic [7:0]   b_sbox_in, b_sbox_out;
    logic         b_sbox_enc;

    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    assign a_sbox_out = a_sbox_enc ? fwd_tab[a_sbox_in] : inv_tab[a_sbox_in];
    assign b_sbox_out = b_sbox_enc ? fwd_tab[b_sbox_in] : inv_tab[b_sbox_in];

    subbytes_seq #(.NBYTES(NA)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_encrypt(a_in_encrypt), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .out_data(a_out_data), .busy(a_busy), .sbox_byte_in(a_sbox_in),
        .sbox_encrypt(a_sbox_enc), .sbox_byte_out(a_sbox_out)
    );

    subbytes_seq #(.NBYTES(NB)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_encrypt(b_in_encrypt), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_data(b_out_data), .busy(b_busy), .sbox_byte_in(b_sbox_in),
        .sbox_encrypt(b_sbox_enc), .sbox_byte_out(b_sbox_out)
    );

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] x_in, input logic [7:0] y_in);
        logic [7:0] x, y, r;
        x = x_in; y = y_in; r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) r = r ^ x;
            y = y >> 1;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] x);
        logic [7:0]  b, s;
        logic [15:0] t;
        b = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (x != 8'h00 && gmul(x, 8'(y)) == 8'h01) b = 8'(y);
        end
        t = {b, b};
        s = b ^ 8'h63;
        for (int k = 1; k <= 4; k++) s = s ^ t[15-k -: 8];
        return s;
    endfunction

    function automatic logic [127:0] ref_sub(input logic [127:0] d, input logic enc, input int n);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = enc ? fwd_tab[d[8*i +: 8]] : inv_tab[d[8*i +: 8]];
        return r;
    endfunction

    logic [127:0] a_exp_q [$];
    int           a_lat_q [$];
    logic [31:0]  b_exp_q [$];
    int           b_lat_q [$];
    logic a_prev_v = 1'b0, a_prev_r = 1'b0, b_prev_v = 1'b0, b_prev_r = 1'b0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && a_in_valid && a_in_ready) a_lat_q.push_back(cyc + NA + Extra + 1);
        if (!rst && b_in_valid && b_in_ready) b_lat_q.push_back(cyc + NB + Extra + 1);
    end

    // Monitor: compare each result on the rising edge of out_valid.
    always @(negedge clk) begin
        if (!rst) begin
            if (a_prev_v && a_prev_r) chk("a_valid_drop", 128'(a_out_valid), 128'(0));
            if (a_out_valid) chk("a_ready_busy", 128'({a_in_ready, a_busy}), 128'(2'b01));
            if (a_out_valid && !a_prev_v) begin
                if (a_exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL a_unexpected: got %h, expected no output", a_out_data);
                end else begin
                    chk("a_data", a_out_data, a_exp_q.pop_front());
                end
                if (a_lat_q.size() != 0) chk("a_latency", 128'(cyc), 128'(a_lat_q.pop_front()));
            end
            if (b_prev_v && b_prev_r) chk("b_valid_drop", 128'(b_out_valid), 128'(0));
            if (b_out_valid && !b_prev_v) begin
                if (b_exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL b_unexpected: got %h, expected no output", b_out_data);
                end else begin
                    chk("b_data", 128'(b_out_data), 128'(b_exp_q.pop_front()));
                end
                if (b_lat_q.size() != 0) chk("b_latency", 128'(cyc), 128'(b_lat_q.pop_front()));
            end
        end
        a_prev_v <= a_out_valid; a_prev_r <= a_out_ready;
        b_prev_v <= b_out_valid; b_prev_r <= b_out_ready;
    end

    task automatic send_a(input logic [127:0] d, input logic enc, input logic push,
                          input logic [127:0] exp);
        int k = 0;
        while (!a_in_ready && k < 200) begin @(negedge clk); k++; end
        if (!a_in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL a_send_timeout: got in_ready=0, expected 1");
        end else begin
            a_in_valid = 1'b1; a_in_data = d; a_in_encrypt = enc;
            if (push) a_exp_q.push_back(exp);
            @(negedge clk);
            a_in_valid = 1'b0;
            a_in_data = {$urandom, $urandom, $urandom, $urandom};
            a_in_encrypt = 1'($urandom);
        end
    endtask

    task automatic send_b(input logic [31:0] d, input logic enc, input logic [31:0] exp);
        int k = 0;
        while (!b_in_ready && k < 200) begin @(negedge clk); k++; end
        if (!b_in_ready) begin
            n_chk++; n_fail++;
            $display("FAIL b_send_timeout: got in_ready=0, expected 1");
        end else begin
            b_in_valid = 1'b1; b_in_data = d; b_in_encrypt = enc;
            b_exp_q.push_back(exp);
            @(negedge clk);
            b_in_valid = 1'b0; b_in_data = $urandom; b_in_encrypt = 1'($urandom);
        end
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((a_exp_q.size() != 0 || b_exp_q.size() != 0 || !a_in_ready || !b_in_ready)
               && k < 300) begin
            @(negedge clk); k++;
        end
        chk(nm, 128'(a_exp_q.size() + b_exp_q.size()), 128'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    logic [127:0] ramp, fwd_ramp, d, e;
    logic         enc;
    int           k;

    initial begin
        for (int i = 0; i < 256; i++) fwd_tab[i] = sbox_fwd(8'(i));
        for (int i = 0; i < 256; i++) inv_tab[fwd_tab[i]] = 8'(i);

        a_in_valid = 0; a_in_data = '0; a_in_encrypt = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = '0; b_in_encrypt = 0; b_out_ready = 0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(a_in_ready), 128'(1));
        chk("rst_out_valid", 128'(a_out_valid), 128'(0));
        chk("rst_busy", 128'(a_busy), 128'(0));
        chk("rst_out_data", a_out_data, 128'(0));
        chk("rst_sbox_in", 128'(a_sbox_in), 128'(0));
        chk("rst_sbox_enc", 128'(a_sbox_enc), 128'(1));

        a_out_ready = 1'b1;
        b_out_ready = 1'b1;
        send_a('0, 1'b1, 1'b1, {16{8'h63}});
        drain("zeros_drain");

        for (int i = 0; i < 16; i++) ramp[8*i +: 8] = 8'(i);
        fwd_ramp = 128'h76abd7fe2b670130c56f6bf27b777c63;
        send_a(ramp, 1'b1, 1'b1, fwd_ramp);
        send_a(fwd_ramp, 1'b0, 1'b1, ramp);
        drain("ramp_drain");
        chk("idle_sbox_enc_holds", 128'(a_sbox_enc), 128'(0));
        chk("idle_sbox_in_zero", 128'(a_sbox_in), 128'(0));

        for (int t = 0; t < 12; t++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            enc = 1'($urandom);
            send_a(d, enc, 1'b1, ref_sub(d, enc, NA));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        drain("rand_drain");

        // Backpressure: result must hold while out_ready is low.
        a_out_ready = 1'b0;
        d = {$urandom, $urandom, $urandom, $urandom};
        e = ref_sub(d, 1'b1, NA);
        send_a(d, 1'b1, 1'b1, e);
        k = 0;
        while (!a_out_valid && k < 100) begin @(negedge clk); k++; end
        chk("bp_valid_seen", 128'(a_out_valid), 128'(1));
        a_in_valid = 1'b1;
        a_in_data = {$urandom, $urandom, $urandom, $urandom};
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid_hold", 128'(a_out_valid), 128'(1));
            chk("bp_data_hold", a_out_data, e);
            chk("bp_in_ready_low", 128'(a_in_ready), 128'(0));
        end
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", 128'(a_in_ready), 128'(1));
        chk("bp_release_valid", 128'(a_out_valid), 128'(0));
        chk("bp_data_retained", a_out_data, e);

        // Mid-transaction reset around idx=7.
        send_a({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, '0);
        repeat (7) @(negedge clk);
        chk("mid_busy_before", 128'(a_busy), 128'(1));
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(a_out_valid), 128'(0));
        chk("mid_rst_ready", 128'(a_in_ready), 128'(1));
        chk("mid_rst_busy", 128'(a_busy), 128'(0));
        chk("mid_rst_data", a_out_data, 128'(0));
        a_lat_q.delete();
        b_lat_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        send_b(32'h53535353, 1'b1, 32'hedededed);
        for (int t = 0; t < 6; t++) begin
            d = {96'h0, $urandom};
            enc = 1'($urandom);
            e = ref_sub(d, enc, NB);
            send_b(d[31:0], enc, e[31:0]);
        end
        drain("subword_drain");

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
